// File: rtl/clk_gen_ctrl.sv
//==============================================================================
// Module : clk_gen_ctrl
// Brief  : Programmable clock generator, f_out = f_clk / (2 * half-period),
//          with whole-period start/stop and glitch-free divisor swap.
//          Optional period counter: CLK_GEN_CTRL_PERIOD_CNT_EN.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module clk_gen_ctrl #(
   parameter int DIV_W = 16
`ifdef CLK_GEN_CTRL_PERIOD_CNT_EN
   ,
   parameter int CNT_W = 32
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             cfg_valid,
   input  logic [DIV_W-1:0] cfg_half,
   output logic             cfg_ready,
   output logic             clk_out,
   output logic             active,
   output logic             rise_pulse,
   output logic             fall_pulse
`ifdef CLK_GEN_CTRL_PERIOD_CNT_EN
   ,
   output logic [CNT_W-1:0] period_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_STOP = 2'd2
   } state_t;

   localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

   state_t           state, state_nx;
   logic [DIV_W-1:0] cnt, cnt_nx;
   logic [DIV_W-1:0] cur_half, cur_nx;
   logic [DIV_W-1:0] pend_half, pend_h_nx;
   logic             pend_valid, pend_v_nx;
   logic             clk_nx, rise_nx, fall_nx;
   logic             accept, wrap;
   logic [DIV_W-1:0] cfg_clamped;

   assign cfg_ready   = !pend_valid;
   assign active      = (state != S_IDLE);
   assign accept      = cfg_valid && !pend_valid;
   assign cfg_clamped = (cfg_half == '0) ? ONE : cfg_half;
   assign wrap        = (cnt == cur_half - ONE);

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      cur_nx    = cur_half;
      pend_h_nx = pend_half;
      pend_v_nx = pend_valid;
      clk_nx    = clk_out;
      rise_nx   = 1'b0;
      fall_nx   = 1'b0;
      case (state)
         S_IDLE: begin
            cnt_nx = '0;
            clk_nx = 1'b0;
            if (pend_valid) begin
               cur_nx    = pend_half;
               pend_v_nx = 1'b0;
            end
            if (run) begin
               state_nx = S_RUN;
               // A config arriving with the start goes straight in, ahead of the first rise.
               if (accept) cur_nx = cfg_clamped;
            end else if (accept) begin
               pend_h_nx = cfg_clamped;
               pend_v_nx = 1'b1;
            end
         end
         S_RUN, S_STOP: begin
            if (wrap) begin
               cnt_nx = '0;
               clk_nx = !clk_out;
               if (!clk_out) begin
                  rise_nx = 1'b1;
               end else begin
                  fall_nx = 1'b1;
                  if (pend_valid) begin
                     cur_nx    = pend_half;
                     pend_v_nx = 1'b0;
                  end
               end
            end else begin
               cnt_nx = cnt + ONE;
            end
            if (run)
               state_nx = S_RUN;
            else if (state == S_STOP && wrap && clk_out)
               state_nx = S_IDLE;
            else
               state_nx = S_STOP;
            if (accept) begin
               pend_h_nx = cfg_clamped;
               pend_v_nx = 1'b1;
            end
         end
         default: begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
            clk_nx   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         cur_half   <= ONE;
         pend_half  <= ONE;
         pend_valid <= 1'b0;
         clk_out    <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         cur_half   <= cur_nx;
         pend_half  <= pend_h_nx;
         pend_valid <= pend_v_nx;
         clk_out    <= clk_nx;
         rise_pulse <= rise_nx;
         fall_pulse <= fall_nx;
      end
   end

`ifdef CLK_GEN_CTRL_PERIOD_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         period_cnt <= '0;
      else if (state == S_IDLE && run)
         period_cnt <= '0;
      else if (state != S_IDLE && wrap && clk_out)
         period_cnt <= period_cnt + 1'b1;
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_clk_gen_ctrl.sv
//==============================================================================
// Module : tb_clk_gen_ctrl
// Brief  : Randomized bench for clk_gen_ctrl against a countdown/queue model.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_clk_gen_ctrl;

   localparam int DIV_W    = 16;
   localparam int PCNT_MOD = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             run = 1'b0;
   logic             cfg_valid = 1'b0;
   logic [DIV_W-1:0] cfg_half = '0;
   logic             cfg_ready, clk_out, active, rise_pulse, fall_pulse;
`ifdef CLK_GEN_CTRL_PERIOD_CNT_EN
   logic [2:0]       period_cnt;
`endif

   clk_gen_ctrl #(
      .DIV_W(DIV_W)
`ifdef CLK_GEN_CTRL_PERIOD_CNT_EN
      ,
      .CNT_W(3)
`endif
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .run        (run),
      .cfg_valid  (cfg_valid),
      .cfg_half   (cfg_half),
      .cfg_ready  (cfg_ready),
      .clk_out    (clk_out),
      .active     (active),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse)
`ifdef CLK_GEN_CTRL_PERIOD_CNT_EN
      ,
      .period_cnt (period_cnt)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model: on/stopping flags, output level, cycles left in this half, divisor queue.
   bit m_on, m_stop, m_lvl, m_rise, m_fall;
   int m_left, m_half, m_pcnt;
   int q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_on = 0; m_stop = 0; m_lvl = 0; m_rise = 0; m_fall = 0;
      m_left = 0; m_half = 1; m_pcnt = 0;
      q.delete();
   endtask

   task automatic model_step();
      bit acc;
      int val;
      acc = cfg_valid && (q.size() == 0);
      val = (cfg_half == 0) ? 1 : int'(cfg_half);
      m_rise = 0;
      m_fall = 0;
      if (!m_on) begin
         if (q.size() > 0) m_half = q.pop_front();
         if (run) begin
            m_on = 1; m_stop = 0; m_lvl = 0; m_pcnt = 0;
            if (acc) m_half = val;
            m_left = m_half;
         end else if (acc) begin
            q.push_back(val);
         end
      end else begin
         m_left--;
         if (m_left == 0) begin
            m_lvl = !m_lvl;
            if (m_lvl) begin
               m_rise = 1;
            end else begin
               m_fall = 1;
               m_pcnt = (m_pcnt + 1) % PCNT_MOD;
               if (q.size() > 0) m_half = q.pop_front();
               if (m_stop && !run) m_on = 0;
            end
            m_left = m_half;
         end
         if (m_on) m_stop = !run;
         if (acc) q.push_back(val);
      end
   endtask

   task automatic compare_all();
      chk("clk_out", 32'(clk_out), 32'(m_lvl));
      chk("active", 32'(active), 32'(m_on));
      chk("cfg_ready", 32'(cfg_ready), 32'(q.size() == 0));
      chk("rise_pulse", 32'(rise_pulse), 32'(m_rise));
      chk("fall_pulse", 32'(fall_pulse), 32'(m_fall));
`ifdef CLK_GEN_CTRL_PERIOD_CNT_EN
      chk("period_cnt", 32'(period_cnt), 32'(m_pcnt));
`endif
   endtask

   task automatic cyc(input bit r, input bit v, input int h, input int n);
      run       = r;
      cfg_valid = v;
      cfg_half  = DIV_W'(h);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         model_step();
         #1;
         compare_all();
      end
   endtask

   // Reset asserted between edges; outputs must clear without a clock edge.
   task automatic reset_mid();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(posedge clk);
      #1;
      compare_all();
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      rst_n = 1'b1;

      // basic run with half=5
      cyc(0, 1, 5, 1);
      cyc(0, 0, 0, 3);
      cyc(1, 0, 0, 27);
      // reconfig while running
      cyc(1, 1, 2, 1);
      cyc(1, 0, 0, 20);
      // stop then re-raise before the fall, then stop fully
      cyc(1, 1, 4, 1);
      cyc(1, 0, 0, 12);
      cyc(0, 0, 0, 2);
      cyc(1, 0, 0, 10);
      cyc(0, 0, 0, 20);
      // zero clamp gives clk/2
      cyc(0, 1, 0, 1);
      cyc(1, 0, 0, 12);
      cyc(0, 0, 0, 6);
      // config accepted in the same cycle as the start
      cyc(1, 1, 3, 1);
      cyc(1, 0, 0, 30);
      cyc(0, 0, 0, 16);
      // long run at half=1 to wrap the period counter, then reset mid-high
      cyc(0, 1, 1, 1);
      cyc(1, 0, 0, 40);
      cyc(0, 1, 4, 1);
      cyc(1, 0, 0, 7);
      reset_mid();

      for (int i = 0; i < 3000; i++) begin
         bit r;
         r = run;
         if ($urandom_range(0, 14) == 0) r = !r;
         cyc(r, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 6)), 1);
         if ($urandom_range(0, 599) == 0) reset_mid();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/clk_gen_ctrl.md
Name: clk_gen_ctrl

Overview:
- Synthesizable programmable clock generator and controller for the simulation-style clock source.
- Derives an output clock from the system clock at f_out = f_clk / (2 × half-period count).
- Sequences start and stop on whole-period boundaries, and swaps frequency glitch-free via a valid/ready config handshake.
- Sits between the register/config layer and any logic needing a slower, software-chosen clock.

Parameters:
- DIV_W, 16: width of the half-period count.
- CNT_W, 32: width of the period counter (optional feature only).

Ports:
- clk, input, 1: system clock; all logic on its rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- run, input, 1: level request; 1 = generate clock, 0 = stop at the end of the current period.
- cfg_valid, input, 1: new half-period offered.
- cfg_half, input, DIV_W: half-period in clk cycles; 0 is treated as 1.
- cfg_ready, output, 1: block can accept a config this cycle.
- clk_out, output, 1: generated clock, registered.
- active, output, 1: 1 while in RUN or STOP_PEND.
- rise_pulse, output, 1: one-cycle pulse in the cycle clk_out becomes 1.
- fall_pulse, output, 1: one-cycle pulse in the cycle clk_out becomes 0.

Behaviour:
- Reset values (rst_n=0, asynchronous):
  - state=IDLE, clk_out=0, active=0, pulses=0.
  - cnt=0, cur_half=1, pend_valid=0, cfg_ready=1.
- Registers:
  - cur_half: active divisor.
  - pend_half / pend_valid: shadow divisor.
  - cnt (DIV_W): half-period counter.
- Handshake:
  - Accept when cfg_valid && cfg_ready; the value is clamped (0→1) and stored in pend_half, and pend_valid is set.
  - cfg_ready = !pend_valid (registered).
  - A second config cannot be accepted until the pending one is applied.
- Apply rule:
  - IDLE: pend_half is copied to cur_half on the next cycle; pend_valid clears.
  - RUN or STOP_PEND: the copy happens only in the cycle clk_out toggles 1→0, so a changed period never truncates a half-cycle.
- Counting (RUN, STOP_PEND):
  - If cnt == cur_half−1: toggle clk_out, cnt=0, pulse rise_pulse or fall_pulse.
  - Otherwise cnt increments.
  - Duty cycle is exactly 50%; period is 2×cur_half clk cycles.
- FSM:
  - IDLE→RUN when run=1. cnt=0 and clk_out=0 on entry. First rise occurs cur_half cycles after the RUN entry cycle.
  - RUN→STOP_PEND when run=0. Counting continues unchanged.
  - STOP_PEND→RUN when run=1 again. No disturbance to the waveform.
  - STOP_PEND→IDLE in the cycle clk_out toggles 1→0. clk_out stays 0.
  - If clk_out is already 0 when run drops, the block finishes the current low half and the following high half, so the full period completes.
  - Minimum half-period is 1, giving clk_out = clk/2.
- active = (state != IDLE).
- Simultaneous events:
  - A config accept in the same cycle as an IDLE→RUN transition is applied before the first rise.
  - A config arriving on an apply boundary becomes pending and waits for the next boundary, because ready is low that cycle.
- Reset mid-operation forces all reset values immediately. The pending config is discarded.

Optional Feature:
- Macro CLK_GEN_CTRL_PERIOD_CNT_EN.
- When defined:
  - Adds output period_cnt [CNT_W-1:0].
  - Cleared on reset and on IDLE→RUN.
  - Increments on each fall_pulse.
  - Wraps modulo 2^CNT_W.
  - Held in IDLE.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
1. Reset values: assert rst_n=0 mid-sim → clk_out=0, active=0, cfg_ready=1 immediately, no clk edge needed.
2. Basic run: cfg_half=5 in IDLE, then run=1 → first rise_pulse 5 cycles after RUN entry, period 10 clk, high 5 / low 5, active=1.
3. Mid-period reconfig: run with half=5, offer cfg_half=2 while clk_out=1 → cfg_ready drops; old high phase stays 5 cycles; new period is 4 from the fall; cfg_ready returns 1 the cycle after the fall.
4. Stop mid-high: half=4, drop run two cycles into the high phase → high phase completes, falls, state IDLE, clk_out stays 0; re-raising run before the fall gives a continuous waveform.
5. Zero clamp: cfg_half=0 → clk_out toggles every cycle (clk/2).
6. Optional counter (macro defined), CNT_W=3: run 9 periods → period_cnt wraps to 1; reset mid-high → clk_out=0 and period_cnt=0 asynchronously.
